// File: rtl/avalon_multi_timer_pkg.sv
// rtl/avalon_multi_timer_pkg.sv - register map and bit positions for the multi-channel timer
package avalon_multi_timer_pkg;

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_CONTROL = 2'd1,
        REG_PERIOD  = 2'd2,
        REG_SNAP    = 2'd3
    } reg_sel_e;

    localparam int DATA_W        = 32;

    localparam int CTL_ITO       = 0;
    localparam int CTL_CONT      = 1;
    localparam int CTL_START     = 2;
    localparam int CTL_STOP      = 3;
    localparam int CTL_PRESC_LSB = 8;

    localparam int ST_TO         = 0;
    localparam int ST_RUN        = 1;

endpackage

// File: rtl/avalon_multi_timer_channel.sv
// rtl/avalon_multi_timer_channel.sv - one prescaled down-counter channel with snapshot and irq
module timer_channel
    import avalon_multi_timer_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int PRESC_W      = 8,
    parameter int PERIOD_RESET = 9999
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_status,
    input  logic              i_wr_control,
    input  logic              i_wr_period,
    input  logic              i_wr_snap,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_status,
    output logic [DATA_W-1:0] o_control,
    output logic [DATA_W-1:0] o_period,
    output logic [DATA_W-1:0] o_snap,
    output logic              o_irq
);

    logic               r_to;
    logic               r_run;
    logic               r_ito;
    logic               r_cont;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pcnt;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_counter;
    logic [CNT_W-1:0]   r_snap;
    logic               r_reload;

    logic w_tick;
    logic w_wrap;
    logic w_start;
    logic w_stop;
    logic w_run_nxt;

    assign w_tick  = r_run && (r_pcnt == r_presc);
    assign w_wrap  = w_tick && (r_counter == '0);
    assign w_start = i_wr_control && i_wdata[CTL_START];
    assign w_stop  = i_wr_control && i_wdata[CTL_STOP];

    // START is applied last so it overrides STOP, one-shot expiry and a forced reload.
    always_comb begin
        w_run_nxt = r_run;
        if (w_wrap && !r_cont) begin
            w_run_nxt = 1'b0;
        end
        if (w_stop || r_reload) begin
            w_run_nxt = 1'b0;
        end
        if (w_start) begin
            w_run_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to      <= 1'b0;
            r_run     <= 1'b0;
            r_ito     <= 1'b0;
            r_cont    <= 1'b0;
            r_presc   <= '0;
            r_pcnt    <= '0;
            r_period  <= CNT_W'(PERIOD_RESET);
            r_counter <= CNT_W'(PERIOD_RESET);
            r_snap    <= '0;
            r_reload  <= 1'b0;
        end else begin
            r_run    <= w_run_nxt;
            r_reload <= i_wr_period;

            if (i_wr_period) begin
                r_period <= i_wdata[CNT_W-1:0];
            end

            if (r_reload || w_wrap) begin
                r_counter <= r_period;
            end else if (w_tick) begin
                r_counter <= r_counter - CNT_W'(1);
            end

            // A timeout in the same cycle as a STATUS write keeps TO set.
            if (w_wrap) begin
                r_to <= 1'b1;
            end else if (i_wr_status) begin
                r_to <= 1'b0;
            end

            if (w_start || !w_run_nxt || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PRESC_W'(1);
            end

            if (i_wr_control) begin
                r_ito   <= i_wdata[CTL_ITO];
                r_cont  <= i_wdata[CTL_CONT];
                r_presc <= i_wdata[CTL_PRESC_LSB +: PRESC_W];
            end

            if (i_wr_snap) begin
                r_snap <= r_counter;
            end
        end
    end

    always_comb begin
        o_status                             = '0;
        o_status[ST_TO]                      = r_to;
        o_status[ST_RUN]                     = r_run;
        o_control                            = '0;
        o_control[CTL_ITO]                   = r_ito;
        o_control[CTL_CONT]                  = r_cont;
        o_control[CTL_PRESC_LSB +: PRESC_W]  = r_presc;
        o_period                             = '0;
        o_period[CNT_W-1:0]                  = r_period;
        o_snap                               = '0;
        o_snap[CNT_W-1:0]                    = r_snap;
    end

    assign o_irq = r_to & r_ito;

endmodule

// File: rtl/avalon_multi_timer.sv
// rtl/avalon_multi_timer.sv - Avalon-MM slave wrapping NUM_CH independent timer channels
module avalon_multi_timer
    import avalon_multi_timer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int PRESC_W      = 8,
    parameter int PERIOD_RESET = 9999
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [$clog2(NUM_CH)+2-1:0] address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic                        irq,
    output logic [NUM_CH-1:0]           irq_vec
);

    int          w_ch_idx;
    reg_sel_e    w_reg;
    logic        w_wr;
    logic [31:0] w_rdata;
    logic [31:0] r_readdata;

    logic [DATA_W-1:0] w_status  [NUM_CH];
    logic [DATA_W-1:0] w_control [NUM_CH];
    logic [DATA_W-1:0] w_period  [NUM_CH];
    logic [DATA_W-1:0] w_snap    [NUM_CH];

    // Channel field may be zero bits wide (NUM_CH=1), so shift rather than slice.
    assign w_ch_idx = int'(address >> 2);
    assign w_reg    = reg_sel_e'(address[1:0]);
    assign w_wr     = chipselect && !write_n;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_sel;
        assign w_sel = w_wr && (w_ch_idx == g);

        timer_channel #(
            .CNT_W        (CNT_W),
            .PRESC_W      (PRESC_W),
            .PERIOD_RESET (PERIOD_RESET)
        ) u_channel (
            .i_clk        (clk),
            .i_rst_n      (reset_n),
            .i_wr_status  (w_sel && (w_reg == REG_STATUS)),
            .i_wr_control (w_sel && (w_reg == REG_CONTROL)),
            .i_wr_period  (w_sel && (w_reg == REG_PERIOD)),
            .i_wr_snap    (w_sel && (w_reg == REG_SNAP)),
            .i_wdata      (writedata),
            .o_status     (w_status[g]),
            .o_control    (w_control[g]),
            .o_period     (w_period[g]),
            .o_snap       (w_snap[g]),
            .o_irq        (irq_vec[g])
        );
    end

    // Unpopulated channel indices fall through to zero.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_idx == i) begin
                case (w_reg)
                    REG_STATUS:  w_rdata = w_status[i];
                    REG_CONTROL: w_rdata = w_control[i];
                    REG_PERIOD:  w_rdata = w_period[i];
                    REG_SNAP:    w_rdata = w_snap[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |irq_vec;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// tb/tb_avalon_multi_timer.sv - directed self-checking bench for avalon_multi_timer
module tb_avalon_multi_timer;

    localparam int NUM_CH       = 3;
    localparam int CNT_W        = 32;
    localparam int PRESC_W      = 8;
    localparam int PERIOD_RESET = 9999;
    localparam int AW           = $clog2(NUM_CH) + 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [AW-1:0]     address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;

    int n_vec     = 0;
    int n_miscmp  = 0;

    always #5 clk = ~clk;

    avalon_multi_timer #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .PRESC_W      (PRESC_W),
        .PERIOD_RESET (PERIOD_RESET)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] ra(input int ch, input int r);
        return AW'(ch * 4 + r);
    endfunction

    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        logic [31:0] rd;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int r = 0; r < 4; r++) begin
                bus_read(ra(ch, r), rd);
                check_val($sformatf("%s ch%0d reg%0d", pfx, ch, r), rd,
                          (r == 2) ? 32'd9999 : 32'd0);
            end
        end
        check_val({pfx, " irq"}, 32'(irq), 32'd0);
        check_val({pfx, " irq_vec"}, 32'(irq_vec), 32'd0);
        bus_write(ra(0, 3), 32'd0);
        bus_read(ra(0, 3), rd);
        check_val({pfx, " ch0 counter"}, rd, 32'd9999);
        bus_write(ra(2, 3), 32'd0);
        bus_read(ra(2, 3), rd);
        check_val({pfx, " ch2 counter"}, rd, 32'd9999);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;

        repeat (3) @(posedge clk);
        #1;
        check_val("in-reset readdata", readdata, 32'd0);
        check_val("in-reset irq", 32'(irq), 32'd0);
        check_val("in-reset irq_vec", 32'(irq_vec), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_state("rst");

        // ch1 continuous, period 4: timeout every 5 cycles
        bus_write(ra(1, 2), 32'd4);
        bus_write(ra(1, 1), 32'h7);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("ch1 cyc%0d irq_vec", k), 32'(irq_vec), (k == 5) ? 32'd2 : 32'd0);
        end
        bus_write(ra(1, 0), 32'd0);
        check_val("ch1 clr irq_vec", 32'(irq_vec), 32'd0);
        check_val("ch1 clr irq", 32'(irq), 32'd0);
        for (int k = 7; k <= 10; k++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("ch1 cyc%0d irq_vec", k), 32'(irq_vec), (k == 10) ? 32'd2 : 32'd0);
        end
        check_val("ch1 irq", 32'(irq), 32'd1);
        bus_write(ra(1, 1), 32'h8);
        bus_write(ra(1, 0), 32'd0);
        bus_read(ra(0, 0), rd);
        check_val("ch0 idle status", rd, 32'd0);
        bus_read(ra(2, 0), rd);
        check_val("ch2 idle status", rd, 32'd0);

        // ch0 one-shot, period 2, prescale 3: timeout 12 cycles after START
        bus_write(ra(0, 2), 32'd2);
        bus_write(ra(0, 1), 32'h0305);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("ch0 cyc%0d irq_vec", k), 32'(irq_vec), (k == 12) ? 32'd1 : 32'd0);
        end
        bus_read(ra(0, 0), rd);
        check_val("ch0 oneshot status", rd, 32'h1);
        bus_write(ra(0, 3), 32'd0);
        bus_read(ra(0, 3), rd);
        check_val("ch0 oneshot counter", rd, 32'd2);
        bus_write(ra(0, 0), 32'd0);
        check_val("ch0 clr irq_vec", 32'(irq_vec), 32'd0);

        // ch2 continuous, period 100: snapshot 21 cycles after START sees 80
        bus_write(ra(2, 2), 32'd100);
        bus_write(ra(2, 1), 32'h6);
        repeat (20) @(posedge clk);
        bus_write(ra(2, 3), 32'd0);
        bus_read(ra(2, 3), rd);
        check_val("ch2 snap", rd, 32'd80);
        bus_write(ra(2, 2), 32'd50);
        address = ra(2, 0);
        @(posedge clk);
        #1;
        check_val("ch2 run before reload", readdata, 32'h2);
        @(posedge clk);
        #1;
        check_val("ch2 run after reload", readdata, 32'h0);
        bus_read(ra(2, 2), rd);
        check_val("ch2 period", rd, 32'd50);
        bus_write(ra(2, 3), 32'd0);
        bus_read(ra(2, 3), rd);
        check_val("ch2 reload counter", rd, 32'd50);

        // START and STOP together: START wins
        bus_write(ra(2, 1), 32'hE);
        bus_read(ra(2, 0), rd);
        check_val("ch2 start+stop", rd, 32'h2);
        bus_write(ra(2, 1), 32'h8);
        bus_read(ra(2, 0), rd);
        check_val("ch2 stop", rd, 32'h0);

        // STATUS write on the timeout edge leaves TO set
        bus_write(ra(1, 2), 32'd3);
        bus_write(ra(1, 1), 32'h7);
        repeat (3) @(posedge clk);
        bus_write(ra(1, 0), 32'd0);
        check_val("ch1 coincide irq_vec", 32'(irq_vec), 32'd2);
        bus_read(ra(1, 0), rd);
        check_val("ch1 coincide status", rd, 32'h3);
        bus_write(ra(1, 1), 32'h8);
        bus_write(ra(1, 0), 32'd0);

        // channel index NUM_CH is unpopulated
        for (int r = 0; r < 4; r++) begin
            bus_write(ra(NUM_CH, r), 32'hFFFF_FFFF);
        end
        for (int r = 0; r < 4; r++) begin
            bus_read(ra(NUM_CH, r), rd);
            check_val($sformatf("nochan reg%0d", r), rd, 32'd0);
        end
        bus_read(ra(0, 1), rd);
        check_val("nochan ch0 control", rd, 32'h0301);
        bus_read(ra(0, 2), rd);
        check_val("nochan ch0 period", rd, 32'd2);
        bus_read(ra(1, 0), rd);
        check_val("nochan ch1 status", rd, 32'd0);
        bus_read(ra(2, 1), rd);
        check_val("nochan ch2 control", rd, 32'd0);
        check_val("nochan irq", 32'(irq), 32'd0);

        // reset in the middle of counting
        bus_write(ra(0, 2), 32'd1);
        bus_write(ra(0, 1), 32'h7);
        bus_write(ra(2, 1), 32'h6);
        repeat (4) @(posedge clk);
        #1;
        check_val("pre-reset irq", 32'(irq), 32'd1);
        address = ra(0, 2);
        @(posedge clk);
        #1;
        check_val("pre-reset readdata", readdata, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async reset readdata", readdata, 32'd0);
        check_val("async reset irq", 32'(irq), 32'd0);
        check_val("async reset irq_vec", 32'(irq_vec), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_state("post-rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
